// File: rtl/axis_arb_pkg.sv
// Shared types for the two-port packet arbiter: FSM states, default widths, port indices,
// and the round-robin pick rule used when both requesters are valid.
package axis_arb_pkg;

  localparam int unsigned AXIS_TDATA_W_DEF = 32;
  localparam int unsigned PKT_CNT_W_DEF    = 16;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  // On a tie the port that did not win last time gets the grant.
  function automatic logic arb_pick(input logic vld0, input logic vld1, input logic last_grant);
    if (vld0 && vld1) return ~last_grant;
    return vld1 ? PORT1 : PORT0;
  endfunction

  function automatic arb_state_e grant_state(input logic port);
    return port ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream beat bundle (data/strb/last with valid-ready); master drives the beat, slave drives tready.
interface axis_if
  import axis_arb_pkg::*;
#(
  parameter int unsigned DW = AXIS_TDATA_W_DEF
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic            tvalid;
  logic            tlast;
  logic            tready;

  modport master (output tdata, tstrb, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_skid_fifo2.sv
// Two-entry in-order register FIFO; head is read straight from storage flops (1-cycle push-to-visible).
// Pushes when full and pops when empty are ignored; the caller throttles with count.
module axis_skid_fifo2
  import axis_arb_pkg::*;
#(
  parameter int unsigned W = AXIS_TDATA_W_DEF + AXIS_TDATA_W_DEF/8 + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok, pop_ok;

  assign push_ok = push && (count_q != 2'd2);
  assign pop_ok  = pop && (count_q != 2'd0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + 2'(push_ok) - 2'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter of two AXI-Stream requesters into one output; 1-cycle latency,
// 1 beat/cycle. Granted tready drops when the 2-entry output buffer is full; the idle port always sees tready=0.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = AXIS_TDATA_W_DEF,
  parameter int unsigned C_PKT_CNT_WIDTH    = PKT_CNT_W_DEF
) (
  input  logic                       axis_aclk,
  input  logic                       axis_aresetn,
  input  logic                       arb_enable,
  axis_if.slave                      s00_axis,
  axis_if.slave                      s01_axis,
  axis_if.master                     m00_axis,
  output logic [C_PKT_CNT_WIDTH-1:0] pkt_cnt0,
  output logic [C_PKT_CNT_WIDTH-1:0] pkt_cnt1,
  output logic                       busy
);

  localparam int unsigned SW = C_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned BW = C_AXIS_TDATA_WIDTH + SW + 1;

  arb_state_e                 state_q, state_d;
  logic                       last_grant_q, last_grant_d;
  logic [C_PKT_CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [C_PKT_CNT_WIDTH-1:0] pkt_cnt1_q, pkt_cnt1_d;
  logic                       rdy0, rdy1, room;
  logic                       push, pop, head_last;
  logic [BW-1:0]              push_dat, head_dat;
  logic [1:0]                 fifo_cnt;

  assign room = (fifo_cnt != 2'd2);

  // At a tlast the finishing port's tvalid belongs to the beat being accepted, so only the
  // other port counts as a fresh request; this hands over with no dead cycle and never parks a grant.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pkt_cnt0_d   = pkt_cnt0_q;
    pkt_cnt1_d   = pkt_cnt1_q;
    rdy0         = 1'b0;
    rdy1         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_enable && (s00_axis.tvalid || s01_axis.tvalid))
          state_d = grant_state(arb_pick(s00_axis.tvalid, s01_axis.tvalid, last_grant_q));
      end
      ST_GNT0: begin
        rdy0 = room;
        if (s00_axis.tvalid && rdy0 && s00_axis.tlast) begin
          last_grant_d = PORT0;
          pkt_cnt0_d   = pkt_cnt0_q + C_PKT_CNT_WIDTH'(1);
          state_d      = (arb_enable && s01_axis.tvalid) ? grant_state(arb_pick(1'b0, 1'b1, PORT0)) : ST_IDLE;
        end
      end
      ST_GNT1: begin
        rdy1 = room;
        if (s01_axis.tvalid && rdy1 && s01_axis.tlast) begin
          last_grant_d = PORT1;
          pkt_cnt1_d   = pkt_cnt1_q + C_PKT_CNT_WIDTH'(1);
          state_d      = (arb_enable && s00_axis.tvalid) ? grant_state(arb_pick(1'b1, 1'b0, PORT1)) : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT1;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
    end
  end

  assign s00_axis.tready = rdy0;
  assign s01_axis.tready = rdy1;

  assign push     = (s00_axis.tvalid && rdy0) || (s01_axis.tvalid && rdy1);
  assign push_dat = (state_q == ST_GNT1) ? {s01_axis.tdata, s01_axis.tstrb, s01_axis.tlast}
                                         : {s00_axis.tdata, s00_axis.tstrb, s00_axis.tlast};
  assign pop      = m00_axis.tvalid && m00_axis.tready;

  axis_skid_fifo2 #(.W(BW)) u_fifo (
    .clk      (axis_aclk),
    .rst_n    (axis_aresetn),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (fifo_cnt)
  );

  assign {m00_axis.tdata, m00_axis.tstrb, head_last} = head_dat;
  assign m00_axis.tvalid = (fifo_cnt != 2'd0);
  assign m00_axis.tlast  = head_last && m00_axis.tvalid;

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
  assign busy     = (state_q != ST_IDLE) || (fifo_cnt != 2'd0);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: single-port, tie, alternation, output stall,
// enable gating, enable drop mid-packet and mid-packet reset.
module tb_axis_packet_arbiter;
  import axis_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arb_en;
  logic [15:0] cnt0, cnt1;
  logic        busy;

  always #5 clk = ~clk;

  axis_if #(.DW(32)) s0 ();
  axis_if #(.DW(32)) s1 ();
  axis_if #(.DW(32)) m  ();

  axis_packet_arbiter #(.C_AXIS_TDATA_WIDTH(32), .C_PKT_CNT_WIDTH(16)) dut (
    .axis_aclk    (clk),
    .axis_aresetn (rst_n),
    .arb_enable   (arb_en),
    .s00_axis     (s0),
    .s01_axis     (s1),
    .m00_axis     (m),
    .pkt_cnt0     (cnt0),
    .pkt_cnt1     (cnt1),
    .busy         (busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_cyc [2];

  logic [31:0] q_dat  [$];
  logic [3:0]  q_strb [$];
  logic        q_last [$];
  int          q_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m.tvalid && m.tready) begin
      q_dat.push_back(m.tdata);
      q_strb.push_back(m.tstrb);
      q_last.push_back(m.tlast);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no completion, required completion before 300000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [31:0] d, input logic l);
    if (p == 0) begin
      s0.tvalid = v; s0.tdata = d; s0.tstrb = d[3:0]; s0.tlast = l;
    end else begin
      s1.tvalid = v; s1.tdata = d; s1.tstrb = d[3:0]; s1.tlast = l;
    end
  endtask

  task automatic clear_q();
    q_dat.delete(); q_strb.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic send_pkt(input int p, input logic [31:0] first, input logic [31:0] step, input int n);
    for (int i = 0; i < n; i++) begin
      logic ok;
      drive(p, 1'b1, first + step * i, (i == n - 1));
      ok = 1'b0;
      for (int t = 0; t < 500 && !ok; t++) begin
        @(negedge clk);
        ok = (p == 0) ? s0.tready : s1.tready;
      end
      if (!ok) begin
        chk($sformatf("accept_timeout_p%0d", p), {63'd0, ok}, 64'd1);
        drive(p, 1'b0, 32'd0, 1'b0);
        return;
      end
      @(posedge clk); #1;
      if (i == 0) acc_cyc[p] = cyc;
    end
    drive(p, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 32'd0, 1'b0);
    drive(1, 1'b0, 32'd0, 1'b0);
    m.tready = 1'b1;
    arb_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready0", s0.tready, 0);
    chk("rst_tready1", s1.tready, 0);
    chk("rst_m_tvalid", m.tvalid, 0);
    chk("rst_m_tlast", m.tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: single port, 5-beat packet
    do_reset();
    send_pkt(0, 32'd1, 32'd1, 5);
    drain();
    chk("t1_beats", q_dat.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_dat%0d", i), q_dat[i], i + 1);
      chk($sformatf("t1_strb%0d", i), q_strb[i], (i + 1) & 15);
      chk($sformatf("t1_last%0d", i), q_last[i], (i == 4));
    end
    chk("t1_span", q_cyc[4] - q_cyc[0], 4);
    chk("t1_latency", q_cyc[0], acc_cyc[0]);
    chk("t1_cnt0", cnt0, 1);
    chk("t1_cnt1", cnt1, 0);
    chk("t1_busy", busy, 0);

    // 2: tie in the same cycle; port 0 wins first, port 1 follows without a gap
    do_reset();
    fork
      send_pkt(0, 32'd1, 32'd1, 5);
      send_pkt(1, 32'd100, 32'd100, 5);
    join
    drain();
    chk("t2_beats", q_dat.size(), 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t2_dat%0d", i), q_dat[i], (i < 5) ? (i + 1) : (100 * (i - 4)));
      chk($sformatf("t2_last%0d", i), q_last[i], (i == 4) || (i == 9));
    end
    chk("t2_span", q_cyc[9] - q_cyc[0], 9);
    chk("t2_cnt0", cnt0, 1);
    chk("t2_cnt1", cnt1, 1);

    // 3: both ports stream three 3-beat packets -> strict alternation
    do_reset();
    fork
      begin for (int k = 0; k < 3; k++) send_pkt(0, 32'h100 * (k + 1), 32'd1, 3); end
      begin for (int k = 0; k < 3; k++) send_pkt(1, 32'h1000 * (k + 1), 32'd1, 3); end
    join
    drain();
    chk("t3_beats", q_dat.size(), 18);
    for (int j = 0; j < 6; j++) begin
      for (int b = 0; b < 3; b++) begin
        logic [31:0] first;
        first = (j % 2 == 0) ? 32'h100 * (j / 2 + 1) : 32'h1000 * (j / 2 + 1);
        chk($sformatf("t3_dat%0d", 3 * j + b), q_dat[3 * j + b], first + b);
        chk($sformatf("t3_last%0d", 3 * j + b), q_last[3 * j + b], (b == 2));
      end
    end
    chk("t3_span", q_cyc[17] - q_cyc[0], 17);
    chk("t3_cnt0", cnt0, 3);
    chk("t3_cnt1", cnt1, 3);

    // 4: downstream stalls 4+ cycles mid-packet
    do_reset();
    fork
      send_pkt(0, 32'h20, 32'd1, 8);
      begin
        repeat (3) @(posedge clk);
        #1 m.tready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t4_fifo_full", dut.fifo_cnt, 2);
        chk("t4_tready0_low", s0.tready, 0);
        chk("t4_m_tvalid", m.tvalid, 1);
        @(posedge clk);
        #1 m.tready = 1'b1;
      end
    join
    drain();
    chk("t4_beats", q_dat.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_dat%0d", i), q_dat[i], 32'h20 + i);
      chk($sformatf("t4_last%0d", i), q_last[i], (i == 7));
    end
    chk("t4_cnt0", cnt0, 1);

    // 5: enable low blocks the grant; raising it grants port 1 one cycle later
    do_reset();
    arb_en = 1'b0;
    drive(1, 1'b1, 32'h55, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_blocked_tready1", s1.tready, 0);
    chk("t5_blocked_busy", busy, 0);
    @(posedge clk);
    #1 arb_en = 1'b1;
    @(negedge clk);
    chk("t5_idle_tready1", s1.tready, 0);
    @(posedge clk); #1;
    chk("t5_gnt1_tready1", s1.tready, 1);
    chk("t5_gnt1_tready0", s0.tready, 0);
    @(posedge clk); #1;
    drive(1, 1'b0, 32'd0, 1'b0);
    drain();
    chk("t5_beats", q_dat.size(), 1);
    chk("t5_dat", q_dat[0], 32'h55);
    chk("t5_cnt1", cnt1, 1);
    chk("t5_busy_end", busy, 0);

    // 6: enable dropped mid-packet; packet completes, then back to idle despite port 1 waiting
    do_reset();
    drive(1, 1'b1, 32'h77, 1'b1);
    fork
      send_pkt(0, 32'h40, 32'd1, 4);
      begin repeat (2) @(posedge clk); #1 arb_en = 1'b0; end
    join
    drain();
    chk("t6_beats", q_dat.size(), 4);
    chk("t6_dat_last", q_dat[3], 32'h43);
    chk("t6_cnt0", cnt0, 1);
    chk("t6_tready1", s1.tready, 0);
    chk("t6_busy", busy, 0);
    drive(1, 1'b0, 32'd0, 1'b0);
    arb_en = 1'b1;

    // 7: reset after beat 3 of a 5-beat packet, then a clean packet
    do_reset();
    drive(0, 1'b1, 32'd1, 1'b0);
    @(posedge clk); #1;
    for (int b = 2; b <= 4; b++) begin
      @(posedge clk); #1;
      drive(0, 1'b1, b, 1'b0);
    end
    chk("t7_pre_m_tvalid", m.tvalid, 1);
    rst_n = 1'b0;
    drive(0, 1'b0, 32'd0, 1'b0);
    #1;
    chk("t7_async_m_tvalid", m.tvalid, 0);
    chk("t7_async_m_tlast", m.tlast, 0);
    chk("t7_async_busy", busy, 0);
    chk("t7_async_tready0", s0.tready, 0);
    chk("t7_async_fifo", dut.fifo_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    send_pkt(0, 32'd100, 32'd100, 5);
    drain();
    chk("t7_beats", q_dat.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t7_dat%0d", i), q_dat[i], 100 * (i + 1));
      chk($sformatf("t7_last%0d", i), q_last[i], (i == 4));
    end
    chk("t7_cnt0", cnt0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 Parameter: C_AXIS_TDATA_WIDTH, 32, data width of all streams; tstrb width is C_AXIS_TDATA_WIDTH/8.
REQ-002 Parameter: C_PKT_CNT_WIDTH, 16, width of each per-port packet counter.
REQ-003 axis_aclk  in  1  single clock for all ports.
REQ-004 axis_aresetn  in  1  reset, asynchronous, active-low.
REQ-005 arb_enable  in  1  high permits new grants; low blocks new grants, and an in-flight packet still completes.
REQ-006 s00_axis_tdata/tstrb/tvalid/tlast  in  W/W/8/1/1  requester 0 stream.
REQ-007 s00_axis_tready  out  1  requester 0 accept.
REQ-008 s01_axis_tdata/tstrb/tvalid/tlast  in  W/W/8/1/1  requester 1 stream.
REQ-009 s01_axis_tready  out  1  requester 1 accept.
REQ-010 m00_axis_tdata/tstrb/tvalid/tlast  out  W/W/8/1/1  arbitrated stream to the shared FIFO.
REQ-011 m00_axis_tready  in  1  downstream accept.
REQ-012 pkt_cnt0, pkt_cnt1  out  C_PKT_CNT_WIDTH  packets accepted per requester.
REQ-013 busy  out  1  high when the state is not IDLE or the output buffer is non-empty.

Function
REQ-014 The block has FSM states IDLE, GNT0 and GNT1, plus a last_grant register.
REQ-015 The arbitration rule: if only one s0n tvalid is high, select that port; if both are high, select the port not equal to last_grant.
REQ-016 From IDLE, when arb_enable=1 and any tvalid is high, the FSM enters the selected GNTn on the next edge, and no beat is accepted in the IDLE cycle.
REQ-017 In GNTn, s0n_axis_tready = (buffer count < 2), and the other port's tready = 0.
REQ-018 In IDLE, both tready outputs are 0.
REQ-019 Beat acceptance is tvalid & tready, and the arbiter never alters an accepted beat's tdata, tstrb or tlast.
REQ-020 Grant is held for the whole packet and switches only after an accepted beat with tlast=1.
REQ-021 On accepted tlast in GNTn, last_grant becomes n and the next state is chosen by REQ-015 using the updated last_grant.
REQ-022 If, after REQ-021, neither tvalid is high or arb_enable=0, the next state is IDLE.
REQ-023 A back-to-back packet from the other port incurs no dead cycle.
REQ-024 Accepted beats enter a 2-entry in-order output buffer; m00 outputs are driven only from buffer registers, with no combinational path from s0n to m00.
REQ-025 m00_axis_tvalid = (count != 0), and data, strb and last come from the head entry.
REQ-026 A push and a pop in the same cycle leave count unchanged.
REQ-027 Latency from input acceptance to m00_axis_tvalid is 1 cycle.
REQ-028 Throughput is 1 beat per cycle when m00_axis_tready=1.
REQ-029 When m00_axis_tready=0, the buffer fills to 2, then the granted tready drops and no beat is lost or duplicated.
REQ-030 pkt_cntn increments by 1 on each accepted tlast from port n and wraps modulo 2^C_PKT_CNT_WIDTH.
REQ-031 arb_enable falling mid-packet does not stall the packet, and the FSM returns to IDLE after its tlast.

Reset
REQ-032 While axis_aresetn=0, asynchronously: state=IDLE, last_grant=1 (port 0 wins the first tie), buffer count=0, pkt_cnt0=pkt_cnt1=0.
REQ-033 While axis_aresetn=0, all tready, m00_axis_tvalid, m00_axis_tlast and busy outputs are 0.
REQ-034 Reset asserted mid-packet discards the partial packet and buffered beats, and the first grant after release follows REQ-016.

Structure
REQ-035 Package axis_arb_pkg holds the FSM state enum, the default width constants and the port-index constants.
REQ-036 The output buffer is sub-module axis_skid_fifo2 (2-entry, push/pop/count); the FSM and counters live in the top level.

Verification
REQ-037 Port 0 only, 5-beat packet 1..5 with tlast on 5, m00_axis_tready=1 -> m00 emits 1,2,3,4,5 on consecutive cycles, tlast only on 5, pkt_cnt0=1.
REQ-038 Both ports are valid in the same cycle, port 0 sending 1..5 and port 1 sending 100..500 -> m00 emits 1..5 then 100..500 with no gap, tlast on 5 and 500, pkt_cnt0=pkt_cnt1=1.
REQ-039 Both ports stream 3 packets each continuously -> strict alternation 0,1,0,1,0,1, and the counters end at 3/3.
REQ-040 m00_axis_tready=0 for 4 cycles mid-packet -> count saturates at 2, the granted tready drops, and the output sequence is intact.
REQ-041 arb_enable=0 with port 1 valid -> no grant and busy=0; arb_enable=1 -> GNT1 one cycle later.
REQ-042 axis_aresetn pulsed low after beat 3 of a 5-beat packet -> outputs are immediately cleared; after release, a new packet 100..500 passes intact and pkt_cnt0=1.
